// File: rtl/clock_pkg.sv
// Shared definitions for the seven-segment clock display decoder.
//   - digit_e : which display digit digitSelect is currently driving
//   - SEG_*   : active-high g..a segment patterns for 0..9 and blank
//   - state_e : frame FSM states
//   - HOUR_W / MIN_W / NUM_SLOTS : output widths and capture slot count
package clock_pkg;

  localparam int unsigned HOUR_W    = 5;
  localparam int unsigned MIN_W     = 6;
  localparam int unsigned NUM_SLOTS = 5;

  typedef enum logic [2:0] {
    DIG_MIN_ONES  = 3'd0,
    DIG_MIN_TENS  = 3'd1,
    DIG_HOUR_ONES = 3'd2,
    DIG_HOUR_TENS = 3'd3,
    DIG_IND       = 3'd4
  } digit_e;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  typedef enum logic [1:0] {
    COLLECT,
    CHECK,
    PUBLISH
  } state_e;

endpackage

// File: rtl/seven_seg_decode.sv
// Combinational seven-segment pattern to BCD digit decoder.
//   seg_i   : segments g..a, active-high
//   digit_o : decoded digit 0..9 (0 when bad)
//   bad_o   : pattern is not a legal digit for this position
// BLANK_IS_ZERO lets a dark digit read as 0 (suppressed leading hour tens).
module seven_seg_decode
  import clock_pkg::*;
#(
  parameter bit BLANK_IS_ZERO = 1'b0
) (
  input  logic [6:0] seg_i,
  output logic [3:0] digit_o,
  output logic       bad_o
);

  always_comb begin
    digit_o = '0;
    bad_o   = 1'b0;
    case (seg_i)
      SEG_0:     digit_o = 4'd0;
      SEG_1:     digit_o = 4'd1;
      SEG_2:     digit_o = 4'd2;
      SEG_3:     digit_o = 4'd3;
      SEG_4:     digit_o = 4'd4;
      SEG_5:     digit_o = 4'd5;
      SEG_6:     digit_o = 4'd6;
      SEG_7:     digit_o = 4'd7;
      SEG_8:     digit_o = 4'd8;
      SEG_9:     digit_o = 4'd9;
      SEG_BLANK: bad_o   = ~BLANK_IS_ZERO;
      default:   bad_o   = 1'b1;
    endcase
  end

endmodule

// File: rtl/display_decoder.sv
// Recovers hour/minute/PM from a multiplexed seven-segment clock display.
//   clkMSec      : 1 ms clock, rising edge
//   resetN       : asynchronous active-low reset
//   milTime      : 1 = 0..23 hours, 0 = 1..12 hours with PM flag
//   segmentData  : [6:0] segments g..a, [7] dp (PM on the indicator digit)
//   digitSelect  : digit being driven (0..4, 5..7 ignored)
//   hour/min/amPm: last accepted frame
//   frameValid / frameChanged / frameError : one-cycle frame status pulses
// Each digit is sampled once per dwell after STABLE_CYCLES stable cycles.
// A full set of five slots is snapshotted, checked, and published.
module display_decoder
  import clock_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 2
) (
  input  logic              clkMSec,
  input  logic              resetN,
  input  logic              milTime,
  input  logic [7:0]        segmentData,
  input  logic [2:0]        digitSelect,
  output logic [HOUR_W-1:0] hour,
  output logic [MIN_W-1:0]  min,
  output logic              amPm,
  output logic              frameValid,
  output logic              frameChanged,
  output logic              frameError
);

  localparam int unsigned      CNT_W   = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);

  logic [2:0]           sel_q;
  logic [CNT_W-1:0]     stab_q, stab_d;
  logic                 sel_changed, sample;
  logic [NUM_SLOTS-1:0] hit, mask_q, mask_d;
  logic [6:0]           slot_q [4];
  logic [6:0]           snap_q [4];
  logic                 pm_q, snap_pm_q;
  logic                 snap_en;
  state_e               state_q, state_d;

  logic [3:0]           dig [4];
  logic [3:0]           bad;
  logic [6:0]           min_full, hour_full;
  logic                 pm_eff, frame_ok, changed;

  logic [HOUR_W-1:0]    hour_q;
  logic [MIN_W-1:0]     min_q;
  logic                 ampm_q, valid_q, changed_q, error_q;

  // Sample on the first cycle the count hits the limit; saturation keeps it single-shot.
  always_comb begin
    sel_changed = (digitSelect != sel_q);
    if (sel_changed)            stab_d = CNT_W'(1);
    else if (stab_q == CNT_MAX) stab_d = stab_q;
    else                        stab_d = stab_q + CNT_W'(1);
    sample = (stab_d == CNT_MAX) && (sel_changed || (stab_q != CNT_MAX));
  end

  always_comb begin
    hit = '0;
    if (sample) begin
      case (digit_e'(digitSelect))
        DIG_MIN_ONES:  hit[0] = 1'b1;
        DIG_MIN_TENS:  hit[1] = 1'b1;
        DIG_HOUR_ONES: hit[2] = 1'b1;
        DIG_HOUR_TENS: hit[3] = 1'b1;
        DIG_IND:       hit[4] = 1'b1;
        default:       hit    = '0;
      endcase
    end
  end

  // A sample landing in the snapshot cycle seeds the new collection.
  always_comb begin
    state_d = state_q;
    snap_en = 1'b0;
    case (state_q)
      COLLECT: begin
        if (mask_q == '1) begin
          snap_en = 1'b1;
          state_d = CHECK;
        end
      end
      CHECK:   state_d = PUBLISH;
      PUBLISH: state_d = COLLECT;
      default: state_d = COLLECT;
    endcase
    mask_d = (snap_en ? '0 : mask_q) | hit;
  end

  always_ff @(posedge clkMSec or negedge resetN) begin
    if (!resetN) begin
      sel_q     <= '0;
      stab_q    <= '0;
      mask_q    <= '0;
      state_q   <= COLLECT;
      pm_q      <= 1'b0;
      snap_pm_q <= 1'b0;
      for (int unsigned i = 0; i < 4; i++) begin
        slot_q[i] <= '0;
        snap_q[i] <= '0;
      end
    end else begin
      sel_q   <= digitSelect;
      stab_q  <= stab_d;
      mask_q  <= mask_d;
      state_q <= state_d;
      for (int unsigned i = 0; i < 4; i++) begin
        if (hit[i]) slot_q[i] <= segmentData[6:0];
        if (snap_en) snap_q[i] <= slot_q[i];
      end
      if (hit[4])  pm_q      <= segmentData[7];
      if (snap_en) snap_pm_q <= pm_q;
    end
  end

  for (genvar g = 0; g < 4; g++) begin : g_dec
    seven_seg_decode #(.BLANK_IS_ZERO(g == 3)) u_dec (
      .seg_i   (snap_q[g]),
      .digit_o (dig[g]),
      .bad_o   (bad[g])
    );
  end

  // 7-bit intermediates hold 99 without wrap; range checks use the full value.
  always_comb begin
    min_full  = 7'(dig[1]) * 7'd10 + 7'(dig[0]);
    hour_full = 7'(dig[3]) * 7'd10 + 7'(dig[2]);
    pm_eff    = milTime ? 1'b0 : snap_pm_q;
    frame_ok  = (bad == '0) && (min_full <= 7'd59) &&
                (milTime ? (hour_full <= 7'd23)
                         : ((hour_full >= 7'd1) && (hour_full <= 7'd12)));
    changed   = ({hour_full[HOUR_W-1:0], min_full[MIN_W-1:0], pm_eff} !=
                 {hour_q, min_q, ampm_q});
  end

  // Results are registered at the end of CHECK so they are visible during PUBLISH.
  always_ff @(posedge clkMSec or negedge resetN) begin
    if (!resetN) begin
      hour_q    <= '0;
      min_q     <= '0;
      ampm_q    <= 1'b0;
      valid_q   <= 1'b0;
      changed_q <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      valid_q   <= 1'b0;
      changed_q <= 1'b0;
      error_q   <= 1'b0;
      if (state_q == CHECK) begin
        if (frame_ok) begin
          hour_q    <= hour_full[HOUR_W-1:0];
          min_q     <= min_full[MIN_W-1:0];
          ampm_q    <= pm_eff;
          valid_q   <= 1'b1;
          changed_q <= changed;
        end else begin
          error_q   <= 1'b1;
        end
      end
    end
  end

  assign hour         = hour_q;
  assign min          = min_q;
  assign amPm         = ampm_q;
  assign frameValid   = valid_q;
  assign frameChanged = changed_q;
  assign frameError   = error_q;

endmodule

// File: tb/tb_display_decoder.sv
// Directed plus randomized bench for display_decoder (STABLE_CYCLES = 2).
// Digits are described as codes: 0..9 digit, 10 blank, 11 illegal pattern.
// Expected results come from the clock-time rules applied to those codes.
module tb_display_decoder;

  logic       clkMSec = 1'b0;
  logic       resetN;
  logic       milTime;
  logic [7:0] segmentData;
  logic [2:0] digitSelect;
  logic [4:0] hour;
  logic [5:0] min;
  logic       amPm, frameValid, frameChanged, frameError;

  display_decoder #(.STABLE_CYCLES(2)) dut (
    .clkMSec      (clkMSec),
    .resetN       (resetN),
    .milTime      (milTime),
    .segmentData  (segmentData),
    .digitSelect  (digitSelect),
    .hour         (hour),
    .min          (min),
    .amPm         (amPm),
    .frameValid   (frameValid),
    .frameChanged (frameChanged),
    .frameError   (frameError)
  );

  always #5 clkMSec = ~clkMSec;

  int checks = 0;
  int passed = 0;
  int n_valid = 0, n_err = 0, n_both = 0;
  int exp_h = 0, exp_m = 0, exp_pm = 0;
  logic [6:0] seg_tab [12];

  always @(negedge clkMSec) begin
    if (frameValid === 1'b1) n_valid++;
    if (frameError === 1'b1) n_err++;
    if (frameValid === 1'b1 && frameError === 1'b1) n_both++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clkMSec);
    #1;
  endtask

  // Hold one digit for a 4-cycle dwell; the DUT samples on the 2nd edge.
  task automatic drive_slot(input int idx, input logic [7:0] seg);
    digitSelect = 3'(idx);
    segmentData = seg;
    repeat (4) tick();
  endtask

  task automatic drive_digit(input int idx, input int code);
    drive_slot(idx, {1'($urandom_range(0, 1)), seg_tab[code]});
  endtask

  task automatic do_reset();
    resetN = 1'b0;
    #1;
    exp_h = 0; exp_m = 0; exp_pm = 0;
  endtask

  // Called right after the dwell holding the completing sample ends.
  task automatic expect_publish(input string tag, input int c0, input int c1,
                                input int c2, input int c3, input bit pm,
                                input bit mil, input int v0, input int e0);
    bit ok, chg, bad_f, pm_e;
    int mm, hh;
    bad_f = (c0 > 9) || (c1 > 9) || (c2 > 9) || (c3 == 11);
    mm    = c1 * 10 + c0;
    hh    = ((c3 == 10) ? 0 : c3) * 10 + c2;
    ok    = !bad_f && (mm <= 59) && (mil ? (hh <= 23) : (hh >= 1 && hh <= 12));
    pm_e  = mil ? 1'b0 : pm;
    chg   = ok && ((hh != exp_h) || (mm != exp_m) || (pm_e != exp_pm));
    if (ok) begin
      exp_h = hh; exp_m = mm; exp_pm = pm_e;
    end
    chk({tag, "_valid"},   frameValid,   ok);
    chk({tag, "_error"},   frameError,   !ok);
    chk({tag, "_changed"}, frameChanged, chg);
    chk({tag, "_hour"},    hour,         exp_h);
    chk({tag, "_min"},     min,          exp_m);
    chk({tag, "_ampm"},    amPm,         exp_pm);
    tick();
    chk({tag, "_nvalid"},  n_valid - v0, ok);
    chk({tag, "_nerr"},    n_err - e0,   !ok);
    chk({tag, "_clear"},   {frameValid, frameError, frameChanged}, 0);
  endtask

  task automatic run_frame(input string tag, input int c0, input int c1, input int c2,
                           input int c3, input bit pm, input bit mil);
    int v0, e0;
    v0 = n_valid; e0 = n_err;
    milTime = mil;
    drive_digit(0, c0);
    drive_digit(1, c1);
    drive_digit(2, c2);
    drive_digit(3, c3);
    drive_slot(4, {pm, 7'($urandom)});
    expect_publish(tag, c0, c1, c2, c3, pm, mil, v0, e0);
  endtask

  initial begin
    int v0, e0;
    int c [4];
    bit rpm, rmil;

    seg_tab[0] = 7'h3F; seg_tab[1] = 7'h06; seg_tab[2]  = 7'h5B; seg_tab[3]  = 7'h4F;
    seg_tab[4] = 7'h66; seg_tab[5] = 7'h6D; seg_tab[6]  = 7'h7D; seg_tab[7]  = 7'h07;
    seg_tab[8] = 7'h7F; seg_tab[9] = 7'h6F; seg_tab[10] = 7'h00; seg_tab[11] = 7'h01;

    milTime = 1'b0; digitSelect = 3'd0; segmentData = 8'h00;
    do_reset();
    repeat (2) tick();
    chk("rst_hour",   hour, 0);
    chk("rst_min",    min, 0);
    chk("rst_ampm",   amPm, 0);
    chk("rst_pulses", {frameValid, frameChanged, frameError}, 0);
    resetN = 1'b1;

    // 11:24 PM, then the identical frame again
    run_frame("first",   4, 2, 1, 1, 1'b1, 1'b0);
    run_frame("repeat",  4, 2, 1, 1, 1'b1, 1'b0);
    // minute 67 rejected
    run_frame("min67",   7, 6, 1, 1, 1'b1, 1'b0);
    // blank/blank hour in 12-hour mode rejected; 23h accepted in 24-hour mode
    run_frame("hour0",   0, 3, 10, 10, 1'b0, 1'b0);
    run_frame("mil23",   5, 4, 3, 2, 1'b1, 1'b1);
    // blank hour tens reads as zero
    run_frame("blank3",  0, 0, 9, 10, 1'b0, 1'b0);
    // ignored digit indices
    v0 = n_valid; e0 = n_err;
    milTime = 1'b0;
    drive_slot(5, 8'hFF);
    drive_slot(6, 8'h3F);
    drive_slot(7, 8'h06);
    chk("idx567_nopulse", (n_valid - v0) + (n_err - e0), 0);
    run_frame("after567", 8, 1, 2, 1, 1'b0, 1'b0);

    // toggling digitSelect never satisfies stability
    v0 = n_valid; e0 = n_err;
    for (int i = 0; i < 20; i++) begin
      digitSelect = 3'(i % 2);
      segmentData = {1'b0, seg_tab[i % 10]};
      tick();
    end
    drive_digit(2, 7);
    drive_digit(3, 0);
    drive_slot(4, 8'h80);
    repeat (3) tick();
    chk("toggle_nopulse", (n_valid - v0) + (n_err - e0), 0);
    drive_digit(0, 9);
    drive_digit(1, 5);
    expect_publish("toggle_done", 9, 5, 7, 0, 1'b1, 1'b0, v0, e0);

    // reset with three slots captured; remaining slots alone must not complete
    drive_digit(0, 1);
    drive_digit(1, 1);
    drive_digit(2, 1);
    do_reset();
    tick();
    chk("midrst_hour", hour, 0);
    chk("midrst_min",  min, 0);
    chk("midrst_ampm", amPm, 0);
    tick();
    digitSelect = 3'd0;
    resetN = 1'b1;
    v0 = n_valid; e0 = n_err;
    milTime = 1'b0;
    drive_digit(3, 0);
    drive_slot(4, 8'h00);
    repeat (3) tick();
    chk("midrst_partial", (n_valid - v0) + (n_err - e0), 0);
    drive_digit(0, 5);
    drive_digit(1, 4);
    drive_digit(2, 8);
    expect_publish("midrst_frame", 5, 4, 8, 0, 1'b0, 1'b0, v0, e0);

    // first frame after reset equal to 00:00 AM is not a change
    do_reset();
    tick();
    digitSelect = 3'd0;
    resetN = 1'b1;
    run_frame("zero_after_rst", 0, 0, 0, 10, 1'b1, 1'b1);

    for (int n = 0; n < 14; n++) begin
      c[0] = $urandom_range(0, 9);
      c[1] = $urandom_range(0, 6);
      c[2] = $urandom_range(0, 9);
      c[3] = $urandom_range(0, 2);
      if ($urandom_range(0, 4) == 0) c[$urandom_range(0, 3)] = $urandom_range(10, 11);
      rpm  = 1'($urandom_range(0, 1));
      rmil = 1'($urandom_range(0, 1));
      run_frame("rand", c[0], c[1], c[2], c[3], rpm, rmil);
    end

    chk("no_overlap", n_both, 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/display_decoder.md
DISPLAY_DECODER -- requirements
Module: display_decoder

Interface
REQ-001 The module SHALL have parameter STABLE_CYCLES, default 2: the number of consecutive cycles digitSelect must hold one value before its segment byte is sampled.
REQ-002 The module SHALL have input clkMSec, 1 bit: the single 1 ms clock; all state is updated on its rising edge.
REQ-003 The module SHALL have input resetN, 1 bit: reset, asynchronous and active-low.
REQ-004 The module SHALL have input milTime, 1 bit: 1 selects the 0..23 hour range; 0 selects the 1..12 hour range plus AM/PM.
REQ-005 The module SHALL have input segmentData, 8 bits: bits [6:0] are segments g..a, active-high; bit 7 is the dp segment.
REQ-006 The module SHALL have input digitSelect, 3 bits: the digit being driven (0 = min ones, 1 = min tens, 2 = hour ones, 3 = hour tens, 4 = indicator).
REQ-007 The module SHALL have output hour, 5 bits: the last accepted hour, binary.
REQ-008 The module SHALL have output min, 6 bits: the last accepted minute, binary.
REQ-009 The module SHALL have output amPm, 1 bit: the last accepted PM flag (1 = PM).
REQ-010 The module SHALL have output frameValid, 1 bit: a one-cycle pulse when a new frame is accepted.
REQ-011 The module SHALL have output frameChanged, 1 bit: a one-cycle pulse, coincident with frameValid, when the accepted value differs from the previous one.
REQ-012 The module SHALL have output frameError, 1 bit: a one-cycle pulse when a completed frame is rejected.

Function
REQ-013 The module SHALL count stability with a saturating counter that restarts at 1 whenever digitSelect differs from its value in the previous cycle.
REQ-014 The module SHALL sample exactly once per dwell, in the cycle the stability count reaches STABLE_CYCLES: it stores segmentData into the slot for digitSelect and sets that slot's mask bit.
REQ-015 The module SHALL ignore digitSelect values 5..7: no slot is stored and no mask bit is set.
REQ-016 A repeat sample of an already-captured slot within the same frame SHALL overwrite that slot.
REQ-017 Slots 0..3 SHALL decode by segments [6:0]: 0x3F=0, 0x06=1, 0x5B=2, 0x4F=3, 0x66=4, 0x6D=5, 0x7D=6, 0x07=7, 0x7F=8, 0x6F=9.
REQ-018 Pattern 0x00 SHALL decode as 0 on slot 3 only; every other pattern, or 0x00 on slots 0..2, SHALL mark the slot bad.
REQ-019 Slot 4 SHALL be sampled for bit 7 only, which gives the PM flag.
REQ-020 The FSM SHALL have the states COLLECT, CHECK and PUBLISH.
REQ-021 In COLLECT, when the mask is 5'b11111, the module SHALL copy the slots to a snapshot, clear the mask, and go to CHECK on the next cycle.
REQ-022 In CHECK, the module SHALL compute min = 10*slot1 + slot0 and hour = 10*slot3 + slot2.
REQ-023 The frame SHALL be valid only if no slot is bad, min <= 59, and hour is 0..23 (milTime = 1) or 1..12 (milTime = 0).
REQ-024 When milTime = 1, amPm from the frame SHALL be forced to 0.
REQ-025 PUBLISH SHALL last one cycle: on a valid frame it updates hour/min/amPm and pulses frameValid (plus frameChanged if the value differs); on an invalid frame it pulses frameError only and holds the outputs. It then returns to COLLECT.
REQ-026 Latency SHALL be 2 cycles from the completing sample to the pulse.
REQ-027 Samples taken during CHECK or PUBLISH SHALL go into the new collection and SHALL NOT be lost.
REQ-028 frameValid and frameError SHALL never be asserted in the same cycle.
REQ-029 The multiply-by-10 SHALL use 4-bit digit inputs with results truncated to the output widths; intermediate widths SHALL be large enough that no wrap occurs for digits 0..9.

Reset
REQ-030 On resetN low, the module SHALL asynchronously set hour = 0, min = 0, amPm = 0, all pulses = 0, mask = 0, stability count = 0, and state = COLLECT.
REQ-031 A reset mid-frame SHALL discard all partially collected slots.
REQ-032 After reset the first accepted frame SHALL assert frameChanged only if its value differs from 00:00 AM.

Structure
REQ-033 Shared package clock_pkg SHALL hold: the digit index enum (DIG_MIN_ONES..DIG_IND), the segment pattern constants for 0..9 and blank, the FSM state enum, and the hour/min widths.
REQ-034 Sub-module seven_seg_decode (pattern in, 4-bit digit plus bad flag out, combinational) SHALL be instanced once per slot 0..3.

Verification
REQ-035 A bench SHALL scan slots 0..4 with patterns 0x66, 0x5B, 0x06, 0x06, 0x80 (milTime = 0, dwell 4) and check frameValid 2 cycles after the slot 4 sample, with hour = 11, min = 24, amPm = 1, and frameChanged = 1.
REQ-036 A bench SHALL repeat the identical frame and check frameValid = 1 with frameChanged = 0.
REQ-037 A bench SHALL send minutes 7,6 (value 67) and check frameError = 1 with outputs unchanged.
REQ-038 A bench SHALL send milTime = 0 with hour 0x00/0x00 (value 0) and check frameError; it SHALL send milTime = 1 with hour 2,3 and check hour = 23 and amPm = 0.
REQ-039 A bench SHALL toggle digitSelect every cycle with STABLE_CYCLES = 2 and check that no sample is taken and no pulse occurs.
REQ-040 A bench SHALL assert resetN low after 3 slots are captured, then send a full frame, and check that exactly one frameValid occurs with the new frame's values.
